// File: rtl/booth_seq_mult.sv
// rtl/booth_seq_mult.sv - sequential radix-4 Booth multiplier, one recoded triplet per cycle
//
// Parameters:
//   WIDTH      operand width in bits (even, >= 4)
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands x/y valid (accepted only in IDLE)
//   in_ready   high only in IDLE
//   x, y       multiplicand / multiplier
//   out_valid  registered, high only in DONE
//   out_ready  consumer accepts product
//   product    2*WIDTH-bit result, held stable in DONE
//   busy       high in CALC and DONE
//   is_signed  (only with BOOTH_UNSIGNED_EN) operand signedness, latched on accept
//
// Build option: define BOOTH_UNSIGNED_EN to add is_signed and unsigned mode.
// Without it every operation is signed.

module booth_seq_mult #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef BOOTH_UNSIGNED_EN
    input  logic                 is_signed,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    // Operands are extended by two bits so that unsigned mode can be handled
    // as a signed multiply with a zero top triplet; the accumulator carries
    // two further bits of headroom for the +/-2X partial product.
    localparam int EW = WIDTH + 2;
    localparam int HW = WIDTH + 4;
    localparam int RW = HW + EW;
    localparam int CW = $clog2(WIDTH / 2 + 2);

    localparam logic [CW-1:0] ITER_S = CW'(WIDTH / 2);
    localparam logic [CW-1:0] ITER_U = CW'(WIDTH / 2 + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [EW-1:0]      x_q, x_d;
    // {accumulator, remaining multiplier bits}; product bits shift in from the top
    logic [RW-1:0]      r_q, r_d;
    logic               ym1_q, ym1_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               out_valid_q, out_valid_d;

    logic               mode_in;
    logic               signed_q;

`ifdef BOOTH_UNSIGNED_EN
    logic signed_d;

    assign mode_in  = is_signed;
    assign signed_d = (state_q == S_IDLE && in_valid) ? is_signed : signed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signed_q <= 1'b1;
        end else begin
            signed_q <= signed_d;
        end
    end
`else
    assign mode_in  = 1'b1;
    assign signed_q = 1'b1;
`endif

    // Operand extension: sign-extend in signed mode, zero-extend otherwise
    logic [EW-1:0] x_in_ext, y_in_ext;
    assign x_in_ext = mode_in ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
    assign y_in_ext = mode_in ? {{2{y[WIDTH-1]}}, y} : {2'b00, y};

    // Booth recoding of {Y[2i+1], Y[2i], Y[2i-1]}
    logic [HW-1:0] xs, x2, mag, pp, sum;
    logic [2:0]    triplet;
    logic          neg;

    assign xs      = {{2{x_q[EW-1]}}, x_q};
    assign x2      = {xs[HW-2:0], 1'b0};
    assign triplet = {r_q[1], r_q[0], ym1_q};

    always_comb begin
        mag = '0;
        neg = 1'b0;
        case (triplet)
            3'b001, 3'b010: begin mag = xs; neg = 1'b0; end
            3'b011:         begin mag = x2; neg = 1'b0; end
            3'b100:         begin mag = x2; neg = 1'b1; end
            3'b101, 3'b110: begin mag = xs; neg = 1'b1; end
            default:        begin mag = '0; neg = 1'b0; end
        endcase
    end

    // Negation folds into the add: ~mag plus a carry-in of one
    assign pp  = neg ? ~mag : mag;
    assign sum = r_q[RW-1:EW] + pp + {{(HW-1){1'b0}}, neg};

    // Accumulate then arithmetic shift right by two across the whole register
    logic [RW-1:0] shifted;
    assign shifted = {{2{sum[HW-1]}}, sum, r_q[EW-1:2]};

    // Signed mode leaves two unconsumed multiplier bits at the bottom;
    // unsigned mode runs one extra step and consumes all of them.
    logic [2*WIDTH-1:0] result;
    assign result = signed_q ? shifted[2 +: 2*WIDTH] : shifted[0 +: 2*WIDTH];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        r_d         = r_q;
        ym1_d       = ym1_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = x_in_ext;
                    r_d     = {{HW{1'b0}}, y_in_ext};
                    ym1_d   = 1'b0;
                    cnt_d   = mode_in ? ITER_S : ITER_U;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                r_d   = shifted;
                ym1_d = r_q[1];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    product_d   = result;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                // No accept on this edge: IDLE must be seen for one cycle first
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            r_q         <= '0;
            ym1_q       <= 1'b0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            r_q         <= r_d;
            ym1_q       <= ym1_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule

// File: doc/booth_seq_mult.md
BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand width in bits; only even values of 4 or more are legal.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operands valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-006 The block SHALL have ports x and y, inputs, WIDTH bits each: multiplicand and multiplier.
REQ-007 The block SHALL have port out_valid, output, 1 bit: product valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: consumer accepts product.
REQ-009 The block SHALL have port product, output, 2*WIDTH bits: the x*y result.
REQ-010 The block SHALL have port busy, output, 1 bit: high in CALC and DONE.

Function
REQ-011 The block SHALL use three states: IDLE, CALC and DONE.
REQ-012 in_ready SHALL be high only in IDLE, so an accept occurs on a clk edge with in_valid=1 while in IDLE.
REQ-013 On accept, the block SHALL latch x and y, clear the accumulator, load an iteration counter and enter CALC.
REQ-014 Each CALC cycle SHALL recode one triplet {y2,y1,y0} = {Y[2i+1],Y[2i],Y[2i-1]}, with Y[-1]=0 and i counting from 0 upward.
REQ-015 The triplet SHALL select the partial product: 000/111 select 0; 001/010 select +X; 011 selects +2X; 100 selects -2X; 101/110 select -X.
REQ-016 Negation SHALL be done as bitwise inversion plus a carry-in of 1 into the same addition, with no separate incrementer.
REQ-017 Each partial product SHALL be sign-extended to the accumulator width and added at weight 4^i; the block SHALL use an accumulate-then-arithmetic-shift-right-by-2 structure.
REQ-018 Signed mode SHALL run exactly WIDTH/2 CALC cycles.
REQ-019 After the last CALC cycle the block SHALL enter DONE with out_valid=1 and product holding the full 2*WIDTH-bit two's-complement result.
REQ-020 Latency SHALL be WIDTH/2+1 clk edges from the accept edge to out_valid=1 (17 for WIDTH=32).
REQ-021 In DONE, product and out_valid SHALL be held stable until out_ready=1, after which the block returns to IDLE on the next edge.
REQ-022 out_valid SHALL be a registered signal that is never asserted outside DONE.
REQ-023 While busy, in_valid SHALL be ignored and the latched operands SHALL be unaffected by changes on x and y.
REQ-024 The DONE-to-IDLE edge SHALL NOT accept new operands, giving a minimum of one bubble and a peak throughput of one product per WIDTH/2+2 cycles.
REQ-025 Overflow SHALL be impossible, and all WIDTH-bit operand pairs SHALL be legal.

Reset
REQ-026 When rst_n=0, the block SHALL go immediately to IDLE with in_ready=1, out_valid=0, busy=0, product=0, and accumulator and counter cleared.
REQ-027 Reset asserted mid-CALC or in DONE SHALL abandon the operation, and no out_valid SHALL follow it.
REQ-028 The first accept SHALL occur no earlier than the first rising clk edge after rst_n deasserts.

Configuration
REQ-029 When macro BOOTH_UNSIGNED_EN is defined, the block SHALL add an input port is_signed, 1 bit, latched on accept.
REQ-030 With BOOTH_UNSIGNED_EN defined and is_signed=0, the operands SHALL be zero-extended to WIDTH+2 bits and the block SHALL run WIDTH/2+1 CALC cycles, giving latency WIDTH/2+2.
REQ-031 With BOOTH_UNSIGNED_EN defined and is_signed=0, product SHALL be the unsigned 2*WIDTH-bit result.
REQ-032 With BOOTH_UNSIGNED_EN defined and is_signed=1, the block SHALL behave exactly as signed mode.
REQ-033 Without BOOTH_UNSIGNED_EN, the is_signed port SHALL be absent and all operations SHALL be signed.

Verification (WIDTH=32)
REQ-034 The bench SHALL apply x=3, y=5 with out_ready=1 and check product=0x000000000000000F with out_valid high exactly on edge 17 after accept.
REQ-035 The bench SHALL apply x=0xFFFFFFFF, y=0xFFFFFFFF in signed mode and check product=0x0000000000000001.
REQ-036 The bench SHALL apply x=0x80000000, y=0x80000000 and check product=0x4000000000000000; it SHALL then apply x=0x7FFFFFFF, y=0x80000000 and check product=0xC000000080000000.
REQ-037 The bench SHALL hold out_ready=0 for 5 cycles after out_valid, toggling in_valid, x and y meanwhile, and check that product stays stable, in_ready=0, and no extra accept occurs.
REQ-038 The bench SHALL drop rst_n during CALC cycle 8 and check that in_ready=1, out_valid=0 and product=0 immediately, with no stale result afterward.
REQ-039 With BOOTH_UNSIGNED_EN defined, the bench SHALL apply is_signed=0, x=y=0xFFFFFFFF and check product=0xFFFFFFFE00000001 with latency 18.
